// File: rtl/jstk_pkg.sv
// rtl/jstk_pkg.sv - shared PmodJSTK frame layout, command prefix and responder states
package jstk_pkg;

    localparam int FRAME_BITS = 40;
    localparam logic [5:0] CMD_LED_PREFIX = 6'b100000;

    // Byte positions within the frame; byte 0 is shifted out first.
    localparam int X_LO_BYTE = 0;
    localparam int X_HI_BYTE = 1;
    localparam int Y_LO_BYTE = 2;
    localparam int Y_HI_BYTE = 3;
    localparam int BTN_BYTE  = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } jstk_state_t;

    // Assemble the MSB-first transmit frame from the joystick inputs.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [9:0] x,
        input logic [9:0] y,
        input logic [2:0] btn
    );
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[FRAME_BITS-1-8*X_LO_BYTE -: 8] = x[7:0];
        f[FRAME_BITS-1-8*X_HI_BYTE -: 8] = {6'b0, x[9:8]};
        f[FRAME_BITS-1-8*Y_LO_BYTE -: 8] = y[7:0];
        f[FRAME_BITS-1-8*Y_HI_BYTE -: 8] = {6'b0, y[9:8]};
        f[FRAME_BITS-1-8*BTN_BYTE  -: 8] = {5'b0, btn};
        return f;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - multi-stage synchronizer with rise/fall pulse detection
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_25,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Synchronizer chain plus one delayed copy for edge detection; resets low so
    // an SS line already low at reset release does not look like a falling edge.
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/jstk_spi_responder.sv
// rtl/jstk_spi_responder.sv - SPI mode-0 slave emulating a PmodJSTK joystick
module jstk_spi_responder
    import jstk_pkg::*;
#(
    parameter int FRAME_BYTES = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_25,
    input  logic       rst,
    input  logic       sclk,
    input  logic       ss,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] buttons,
    output logic [1:0] led,
    output logic [7:0] cmd_byte,
    output logic       xfer_done,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [5:0] LAST_CNT = 6'(FRAME_BYTES * 8);

    logic sclk_rise, sclk_fall, sclk_level;
    logic ss_rise, ss_fall, ss_level;
    logic mosi_s, unused_mosi_rise, unused_mosi_fall;
    logic unused_levels;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_25(clk_25), .rst(rst), .din(sclk),
        .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ss (
        .clk_25(clk_25), .rst(rst), .din(ss),
        .level(ss_level), .rise(ss_rise), .fall(ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_25(clk_25), .rst(rst), .din(mosi),
        .level(mosi_s), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    assign unused_levels = sclk_level ^ ss_level;

    jstk_state_t           state, state_n;
    logic [5:0]            bit_cnt, bit_cnt_n;
    logic [FRAME_BITS-1:0] tx, tx_n;
    logic [7:0]            rx, rx_n;
    logic [7:0]            pending, pending_n;
    logic                  miso_n, miso_oe_n, busy_n, xfer_done_n, frame_err_n;
    logic [1:0]            led_n;
    logic [7:0]            cmd_byte_n;

    // State and datapath registers; reset drops any frame in flight silently.
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            tx        <= '0;
            rx        <= '0;
            pending   <= '0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            busy      <= 1'b0;
            xfer_done <= 1'b0;
            frame_err <= 1'b0;
            led       <= 2'b00;
            cmd_byte  <= 8'h00;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            tx        <= tx_n;
            rx        <= rx_n;
            pending   <= pending_n;
            miso      <= miso_n;
            miso_oe   <= miso_oe_n;
            busy      <= busy_n;
            xfer_done <= xfer_done_n;
            frame_err <= frame_err_n;
            led       <= led_n;
            cmd_byte  <= cmd_byte_n;
        end
    end

    // Next-state logic; an SS rise takes priority over any SCLK edge in the same cycle.
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        tx_n        = tx;
        rx_n        = rx;
        pending_n   = pending;
        miso_n      = miso;
        miso_oe_n   = miso_oe;
        busy_n      = busy;
        xfer_done_n = 1'b0;
        frame_err_n = 1'b0;
        led_n       = led;
        cmd_byte_n  = cmd_byte;

        if (ss_rise) begin
            state_n   = IDLE;
            miso_n    = 1'b0;
            miso_oe_n = 1'b0;
            busy_n    = 1'b0;
            bit_cnt_n = '0;
            if (state != IDLE) begin
                if (bit_cnt == LAST_CNT) begin
                    xfer_done_n = 1'b1;
                    cmd_byte_n  = pending;
                    if (pending[7:2] == CMD_LED_PREFIX) begin
                        led_n = pending[1:0];
                    end
                end else if (bit_cnt != 6'd0) begin
                    frame_err_n = 1'b1;
                end
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state_n   = SHIFT;
                        tx_n      = build_frame(x_pos, y_pos, buttons);
                        miso_n    = tx_n[FRAME_BITS-1];
                        miso_oe_n = 1'b1;
                        busy_n    = 1'b1;
                        bit_cnt_n = '0;
                        rx_n      = '0;
                        pending_n = '0;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        rx_n      = {rx[6:0], mosi_s};
                        bit_cnt_n = bit_cnt + 6'd1;
                        if (bit_cnt_n == 6'd8) begin
                            pending_n = rx_n;
                        end
                        if (bit_cnt_n == LAST_CNT) begin
                            state_n = DONE;
                            miso_n  = 1'b0;
                        end
                    end else if (sclk_fall) begin
                        tx_n   = {tx[FRAME_BITS-2:0], 1'b0};
                        miso_n = tx_n[FRAME_BITS-1];
                    end
                end
                DONE: begin
                    miso_n = 1'b0;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jstk_spi_responder.sv
// tb/tb_jstk_spi_responder.sv - directed self-checking bench for jstk_spi_responder
module tb_jstk_spi_responder;

    logic       clk_25 = 1'b0;
    logic       rst;
    logic       sclk, ss, mosi;
    logic       miso, miso_oe;
    logic [9:0] x_pos, y_pos;
    logic [2:0] buttons;
    logic [1:0] led;
    logic [7:0] cmd_byte;
    logic       xfer_done, frame_err, busy;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int extra_ones = 0;
    logic [39:0] rx_bits;

    jstk_spi_responder dut (
        .clk_25(clk_25), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .x_pos(x_pos), .y_pos(y_pos),
        .buttons(buttons), .led(led), .cmd_byte(cmd_byte),
        .xfer_done(xfer_done), .frame_err(frame_err), .busy(busy)
    );

    always #20 clk_25 = ~clk_25;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk_25) begin
        if (xfer_done) done_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic ss_low();
        @(negedge clk_25);
        ss = 1'b0;
        repeat (8) @(negedge clk_25);
    endtask

    // Clock bits [first,last) of a frame; miso is sampled just before each rise.
    task automatic xfer_bits(input logic [39:0] tx, input int first, input int last);
        for (int i = first; i < last; i++) begin
            mosi = (i < 40) ? tx[39-i] : 1'b0;
            repeat (12) @(negedge clk_25);
            if (i < 40) rx_bits[39-i] = miso;
            else if (miso) extra_ones++;
            sclk = 1'b1;
            repeat (12) @(negedge clk_25);
            sclk = 1'b0;
        end
        mosi = 1'b0;
    endtask

    task automatic ss_high();
        repeat (6) @(negedge clk_25);
        ss = 1'b1;
        repeat (6) @(negedge clk_25);
    endtask

    task automatic full_frame(input logic [7:0] cmd);
        done_cnt = 0;
        err_cnt  = 0;
        ss_low();
        check("busy_in_frame", {39'b0, busy}, 40'd1);
        xfer_bits({cmd, 32'h0}, 0, 40);
        ss_high();
    endtask

    initial begin
        rst = 1'b1; sclk = 1'b0; ss = 1'b1; mosi = 1'b0;
        x_pos = 10'd0; y_pos = 10'd0; buttons = 3'b000;
        repeat (4) @(negedge clk_25);
        check("rst_outs", {33'b0, miso, miso_oe, busy, xfer_done, frame_err, led}, 40'd0);
        check("rst_cmd", {32'b0, cmd_byte}, 40'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk_25);
        check("idle_no_pulse", done_cnt + err_cnt, 40'd0);

        // Basic frame with LED command
        x_pos = 10'd512; y_pos = 10'd300; buttons = 3'b101;
        full_frame(8'h83);
        check("basic_miso", rx_bits, 40'h00_02_2C_01_05);
        check("basic_led", {38'b0, led}, 40'd3);
        check("basic_cmd", {32'b0, cmd_byte}, 40'h83);
        check("basic_done", done_cnt, 40'd1);
        check("basic_idle", {38'b0, busy, miso_oe}, 40'd0);

        // Non-LED command leaves led alone
        full_frame(8'h40);
        check("nonled_cmd", {32'b0, cmd_byte}, 40'h40);
        check("nonled_led", {38'b0, led}, 40'd3);
        check("nonled_done", done_cnt, 40'd1);

        // Aborted frame after 12 bits, with exact pulse latency
        done_cnt = 0; err_cnt = 0;
        ss_low();
        xfer_bits({8'h81, 32'h0}, 0, 12);
        repeat (6) @(negedge clk_25);
        ss = 1'b1;
        repeat (2) @(negedge clk_25);
        check("abort_oe_still", {38'b0, miso_oe, frame_err}, 40'b10);
        @(negedge clk_25);
        check("abort_pulse_t3", {38'b0, miso_oe, frame_err}, 40'b01);
        repeat (4) @(negedge clk_25);
        check("abort_err_cnt", err_cnt, 40'd1);
        check("abort_done_cnt", done_cnt, 40'd0);
        check("abort_cmd", {30'b0, led, cmd_byte}, {30'b0, 2'b11, 8'h40});

        // Snapshot stability: x changes during byte 1
        x_pos = 10'd100;
        done_cnt = 0; err_cnt = 0;
        ss_low();
        xfer_bits({8'h82, 32'h0}, 0, 12);
        x_pos = 10'd900;
        xfer_bits({8'h82, 32'h0}, 12, 40);
        ss_high();
        check("snap_first", rx_bits, 40'h64_00_2C_01_05);
        check("snap_led", {38'b0, led}, 40'd2);
        full_frame(8'h00);
        check("snap_second", rx_bits, 40'h84_03_2C_01_05);
        check("snap_led_hold", {30'b0, led, cmd_byte}, {30'b0, 2'b10, 8'h00});

        // Overclock: 45 SCLK pulses in one frame
        done_cnt = 0; err_cnt = 0; extra_ones = 0;
        ss_low();
        xfer_bits({8'h81, 32'h0}, 0, 45);
        ss_high();
        check("over_miso", rx_bits, 40'h84_03_2C_01_05);
        check("over_extra_zero", extra_ones, 40'd0);
        check("over_done", {30'b0, done_cnt[1:0], cmd_byte}, {30'b0, 2'd1, 8'h81});
        check("over_led", {38'b0, led}, 40'd1);

        // Stray SCLK with SS high
        done_cnt = 0; err_cnt = 0;
        xfer_bits(40'hFF_FF_FF_FF_FF, 0, 10);
        check("stray_outs", {38'b0, miso, miso_oe} | {39'b0, busy}, 40'd0);
        check("stray_pulses", done_cnt + err_cnt, 40'd0);
        check("stray_regs", {30'b0, led, cmd_byte}, {30'b0, 2'b01, 8'h81});

        // Reset mid-frame at bit 20
        done_cnt = 0; err_cnt = 0;
        ss_low();
        xfer_bits({8'h80, 32'h0}, 0, 20);
        rst = 1'b1;
        #1;
        check("rst_mid_outs", {33'b0, miso, miso_oe, busy, xfer_done, frame_err, led}, 40'd0);
        check("rst_mid_cmd", {32'b0, cmd_byte}, 40'd0);
        repeat (3) @(negedge clk_25);
        rst = 1'b0;
        repeat (8) @(negedge clk_25);
        check("rst_ss_low_ignored", {39'b0, busy}, 40'd0);
        ss = 1'b1;
        repeat (8) @(negedge clk_25);
        check("rst_no_err", err_cnt + done_cnt, 40'd0);
        x_pos = 10'd1023; y_pos = 10'd0; buttons = 3'b010;
        full_frame(8'h82);
        check("post_rst_miso", rx_bits, 40'hFF_03_00_00_02);
        check("post_rst_regs", {30'b0, led, cmd_byte}, {30'b0, 2'b10, 8'h82});
        check("post_rst_done", done_cnt, 40'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
